fp16_stream_argmax: RTL and testbench

FP16_STREAM_ARGMAX -- requirements
Module: fp16_stream_argmax

---
 rtl/fp16_stream_argmax.sv | 162 ++++++++++++++++
 tb/tb_fp16_stream_argmax.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_stream_argmax.sv
// fp16_stream_argmax
//   Streams a vector of IEEE half-precision values and reports the maximum
//   element together with its zero-based position in the vector.
//   - Equal values keep the earlier element.
//   - +0 and -0 compare equal.
//   - NaNs never win, but they set a sticky flag.
//   - A vector made only of NaNs reports the canonical quiet NaN 16'h7E00.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input beat offered
//   in_ready_o   block can accept a beat (low while a result is held)
//   in_data_i    fp16 element
//   in_last_i    final element of the vector
//   out_valid_o  result presented
//   out_ready_i  consumer takes the result
//   out_max_o    maximum element
//   out_idx_o    position of out_max_o (saturates at 2^IDX_W-1)
//   out_nan_o    at least one NaN seen in the vector
//   out_ovf_o    vector length overflowed the index counter
module fp16_stream_argmax #(
   parameter int IDX_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [15:0]       in_data_i,
   input  logic              in_last_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [15:0]       out_max_o,
   output logic [IDX_W-1:0]  out_idx_o,
   output logic              out_nan_o,
   output logic              out_ovf_o
);

   typedef enum logic [1:0] {EMPTY, ACC, OUT} state_e;

   localparam logic [IDX_W-1:0] CNT_MAX = '1;
   localparam logic [15:0]      QNAN    = 16'h7E00;

   state_e             state_q, state_d;
   logic [15:0]        max_q, max_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               nan_q, nan_d;
   logic               ovf_q, ovf_d;
   // Running max currently holds the canonical NaN (only possible when the
   // first beat was a NaN); any later non-NaN beat must replace it.
   logic               max_is_nan_q, max_is_nan_d;

   logic               accept;
   logic               in_nan;
   logic               in_greater;

   // Maps an fp16 value onto an unsigned key whose ordering matches the
   // IEEE total order for non-NaN values. Both zeros map to the same key so
   // they tie. Negative values are bit-inverted so larger magnitude sorts lower.
   function automatic logic [15:0] order_key(input logic [15:0] x);
      logic [15:0] k;
      if (x[14:0] == 15'd0) begin
         k = 16'h8000;
      end else if (x[15]) begin
         k = ~x;
      end else begin
         k = {1'b1, x[14:0]};
      end
      return k;
   endfunction

   assign accept     = in_valid_i && (state_q != OUT);
   assign in_nan     = (&in_data_i[14:10]) && (|in_data_i[9:0]);
   assign in_greater = order_key(in_data_i) > order_key(max_q);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= EMPTY;
         max_q        <= 16'h0000;
         idx_q        <= '0;
         cnt_q        <= '0;
         nan_q        <= 1'b0;
         ovf_q        <= 1'b0;
         max_is_nan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         max_q        <= max_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         nan_q        <= nan_d;
         ovf_q        <= ovf_d;
         max_is_nan_q <= max_is_nan_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      max_d        = max_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      nan_d        = nan_q;
      ovf_d        = ovf_q;
      max_is_nan_d = max_is_nan_q;

      case (state_q)
         EMPTY: begin
            if (accept) begin
               // A leading NaN is held as the canonical NaN so an all-NaN
               // vector reports 16'h7E00 without extra output muxing.
               max_d        = in_nan ? QNAN : in_data_i;
               max_is_nan_d = in_nan;
               nan_d        = in_nan;
               ovf_d        = 1'b0;
               idx_d        = '0;
               cnt_d        = IDX_W'(1);
               state_d      = in_last_i ? OUT : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               if (in_nan) begin
                  nan_d = 1'b1;
               end else if (max_is_nan_q || in_greater) begin
                  max_d        = in_data_i;
                  idx_d        = cnt_q;
                  max_is_nan_d = 1'b0;
               end
               if (cnt_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
               if (in_last_i) begin
                  state_d = OUT;
               end
            end
         end
         OUT: begin
            if (out_ready_i) begin
               state_d = EMPTY;
               nan_d   = 1'b0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   assign in_ready_o  = (state_q != OUT);
   assign out_valid_o = (state_q == OUT);
   assign out_max_o   = max_q;
   assign out_idx_o   = idx_q;
   assign out_nan_o   = nan_q;
   assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_fp16_stream_argmax.sv
// Testbench for fp16_stream_argmax. Two instances are used: IDX_W=8 and
// IDX_W=2, selected by 'sel'. A queue/real-arithmetic model predicts every
// result; a negedge process compares the DUT against it each cycle, and the
// directed sequence also checks hand-computed literal results.
module tb_fp16_stream_argmax;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, out_valid_a, nan_a, ovf_a;
   logic [15:0] max_a;
   logic [7:0]  idx_a;
   logic        in_ready_b, out_valid_b, nan_b, ovf_b;
   logic [15:0] max_b;
   logic [1:0]  idx_b;

   logic        in_ready, out_valid, out_nan, out_ovf;
   logic [15:0] out_max;
   logic [7:0]  out_idx;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fp16_stream_argmax #(.IDX_W(8)) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid && !sel), .in_ready_o(in_ready_a),
      .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid_a), .out_ready_i(out_ready),
      .out_max_o(max_a), .out_idx_o(idx_a),
      .out_nan_o(nan_a), .out_ovf_o(ovf_a)
   );

   fp16_stream_argmax #(.IDX_W(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid && sel), .in_ready_o(in_ready_b),
      .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid_b), .out_ready_i(out_ready),
      .out_max_o(max_b), .out_idx_o(idx_b),
      .out_nan_o(nan_b), .out_ovf_o(ovf_b)
   );

   assign in_ready  = sel ? in_ready_b  : in_ready_a;
   assign out_valid = sel ? out_valid_b : out_valid_a;
   assign out_max   = sel ? max_b       : max_a;
   assign out_idx   = sel ? {6'd0, idx_b} : idx_a;
   assign out_nan   = sel ? nan_b       : nan_a;
   assign out_ovf   = sel ? ovf_b       : ovf_a;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit fp_is_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
   endfunction

   function automatic real fp_val(input logic [15:0] x);
      real mag;
      int  e;
      e = int'(x[14:10]);
      if (e == 31) begin
         mag = 1.0e30;
      end else if (e == 0) begin
         mag = real'(int'(x[9:0])) / 16777216.0;
      end else begin
         mag = real'(int'(x[9:0]) + 1024);
         if (e >= 25) for (int k = 0; k < e - 25; k++) mag = mag * 2.0;
         else         for (int k = 0; k < 25 - e; k++) mag = mag / 2.0;
      end
      return x[15] ? -mag : mag;
   endfunction

   logic [15:0] mq[$];
   bit          m_valid = 1'b0;
   logic [15:0] m_max;
   int          m_idx;
   bit          m_nan, m_ovf;

   task automatic model_finish();
      bit  have;
      real bv;
      int  bi, lim;
      have = 0; bv = 0.0; bi = 0;
      lim = sel ? 3 : 255;
      m_nan = 0;
      m_max = 16'h7E00;
      foreach (mq[i]) begin
         if (fp_is_nan(mq[i])) begin
            m_nan = 1;
         end else if (!have || fp_val(mq[i]) > bv) begin
            have = 1; bv = fp_val(mq[i]); bi = i; m_max = mq[i];
         end
      end
      m_idx = (bi > lim) ? lim : bi;
      // the counter saturates at lim; every beat taken at saturation flags overflow
      m_ovf = (mq.size() > lim);
      m_valid = 1;
      mq.delete();
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 0;
         mq.delete();
      end else if (m_valid) begin
         if (out_ready) m_valid = 0;
      end else if (in_valid) begin
         mq.push_back(in_data);
         if (in_last) model_finish();
      end
   end

   initial forever begin
      @(negedge rst_n);
      m_valid = 0;
      mq.delete();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_max", 32'(out_max), 32'd0);
         chk("rst_out_idx", 32'(out_idx), 32'd0);
         chk("rst_flags", {30'd0, out_nan, out_ovf}, 32'd0);
      end else begin
         chk("cyc_in_ready", 32'(in_ready), 32'(!m_valid));
         chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("cyc_max", 32'(out_max), 32'(m_max));
            chk("cyc_idx", 32'(out_idx), 32'(m_idx));
            chk("cyc_nan", 32'(out_nan), 32'(m_nan));
            chk("cyc_ovf", 32'(out_ovf), 32'(m_ovf));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic beat(input logic [15:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      in_last  = 1'b0;
   endtask

   // Called one step after the last beat's edge: checks latency and the
   // hand-computed result, then lets the handshake happen if out_ready is high.
   task automatic expect_res(input string name, input logic [15:0] mx, input int ix,
                             input bit nn, input bit ov);
      chk({name, "_latency"}, 32'(out_valid), 32'd1);
      chk({name, "_max"}, 32'(out_max), 32'(mx));
      chk({name, "_idx"}, 32'(out_idx), 32'(ix));
      chk({name, "_nan"}, 32'(out_nan), 32'(nn));
      chk({name, "_ovf"}, 32'(out_ovf), 32'(ov));
      $display("vector %s: max=%h idx=%0d nan=%0d ovf=%0d", name, out_max, out_idx, out_nan, out_ovf);
      if (out_ready) begin
         @(posedge clk);
         #1;
         chk({name, "_released"}, 32'(out_valid), 32'd0);
      end
   endtask

   task automatic pulse_reset(input string name);
      #2 rst_n = 1'b0;
      #1;
      chk({name, "_valid_now"}, 32'(out_valid), 32'd0);
      chk({name, "_ready_now"}, 32'(in_ready), 32'd1);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("init_ready", 32'(in_ready), 32'd1);
      chk("init_valid", 32'(out_valid), 32'd0);
      chk("init_max", 32'(out_max), 32'd0);
      #21 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ordinary vector, tie keeps earliest
      beat(16'h3C00, 0); beat(16'h4000, 0); beat(16'hC000, 0); beat(16'h4000, 1);
      expect_res("basic", 16'h4000, 1, 0, 0);
      // signed zeros tie
      beat(16'h8000, 0); beat(16'h0000, 1);
      expect_res("zeros", 16'h8000, 0, 0, 0);
      // negatives including -inf
      beat(16'hFC00, 0); beat(16'hC400, 0); beat(16'hFBFF, 1);
      expect_res("neg", 16'hC400, 1, 0, 0);
      // leading NaN replaced, +inf ordinary
      beat(16'h7E01, 0); beat(16'h3800, 0); beat(16'h7C00, 1);
      expect_res("nan_lead", 16'h7C00, 2, 1, 0);
      // all NaN
      beat(16'h7E00, 0); beat(16'hFE00, 1);
      expect_res("all_nan", 16'h7E00, 0, 1, 0);
      // NaN in the middle
      beat(16'h3C00, 0); beat(16'h7C01, 0); beat(16'h3800, 1);
      expect_res("nan_mid", 16'h3C00, 0, 1, 0);

      // back-pressure: result held, next beat waits for the handshake
      out_ready = 1'b0;
      beat(16'hBC00, 0); beat(16'hC000, 1);
      expect_res("bp", 16'hBC00, 0, 0, 0);
      in_valid = 1'b1; in_data = 16'h4400; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_hold_max", 32'(out_max), 32'h0000BC00);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_bubble", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_res("bp_next", 16'h4400, 0, 0, 0);

      // reset while a result is held
      out_ready = 1'b0;
      beat(16'h3C00, 1);
      chk("held_before_rst", 32'(out_valid), 32'd1);
      pulse_reset("rst_out");
      out_ready = 1'b1;
      beat(16'h3800, 0); beat(16'h3400, 1);
      expect_res("after_rst", 16'h3800, 0, 0, 0);

      // narrow index instance
      sel = 1'b1;
      @(posedge clk);
      #1;
      beat(16'h4000, 0); beat(16'h4200, 0); beat(16'h3C00, 1);
      expect_res("w2_short", 16'h4200, 1, 0, 0);
      for (int i = 0; i < 5; i++) beat(16'h3C00, 0);
      beat(16'h4000, 1);
      expect_res("w2_ovf_last", 16'h4000, 3, 0, 1);
      beat(16'h3C00, 0); beat(16'h3C00, 0); beat(16'h4400, 0); beat(16'h3800, 0); beat(16'h4400, 1);
      expect_res("w2_ovf_mid", 16'h4400, 2, 0, 1);
      // reset mid-vector discards the partial result
      beat(16'h3C00, 0); beat(16'h4000, 0);
      pulse_reset("rst_mid");
      beat(16'h3800, 1);
      expect_res("w2_after_rst", 16'h3800, 0, 0, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
